// File: rtl/ntru_pkg.sv
// Shared NTRU Rq0 decode constants and types.
// Frame geometry is derived from N and LOGQ.
package ntru_pkg;
  localparam int N      = 701;
  localparam int LOGQ   = 13;
  localparam int Q      = 1 << LOGQ;
  localparam int NBYTES = ((N - 1) * LOGQ + 7) / 8;
  localparam int ACCW   = 20;
  localparam int CNTW   = 5;
  localparam int RXW    = 11;
  localparam int IDXW   = 10;

  typedef logic [LOGQ-1:0] coef_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINAL,
    S_DONE
  } state_e;
endpackage

// File: rtl/unpack_rq0_stream_if.sv
// Byte-in / coefficient-out handshake bundle for the Rq0 unpacker.
// slave = decoder side, master = producer/consumer side.
interface unpack_rq0_stream_if;
    import ntru_pkg::*;

    logic              start;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    coef_t             coef;
    logic [IDXW-1:0]   coef_idx;
    logic              coef_valid;
    logic              coef_ready;
    logic              coef_last;
    logic              done;
    logic              pad_err;

    modport slave (
        input  start, in_byte, in_valid, coef_ready,
        output in_ready, coef, coef_idx, coef_valid,
        output coef_last, done, pad_err
    );

    modport master (
        output start, in_byte, in_valid, coef_ready,
        input  in_ready, coef, coef_idx, coef_valid,
        input  coef_last, done, pad_err
    );
endinterface

// File: rtl/unpack_rq0_stream_last.sv
// Running coefficient sum mod q and its negation, which recovers the
// final Rq0 coefficient (all coefficients of an Rq0 poly sum to zero).
module rq0_last_coef
    import ntru_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr_i,
    input  logic  add_i,
    input  coef_t coef_i,
    output coef_t neg_o
);

    coef_t sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + coef_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign neg_o = (~sum_q) + coef_t'(1);

endmodule

// File: rtl/unpack_rq0_stream.sv
// Packed Rq0 stream decoder: 1138 bytes in, 701 13-bit coefficients out.
// Optional macro UNPACK_PAD_CHECK_EN flags nonzero pad bits in pad_err.
module unpack_rq0_stream
    import ntru_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    unpack_rq0_stream_if.slave  bus
);

    state_e          state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [RXW-1:0]  rx_q, rx_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic  in_rdy, c_vld, c_last, dn;
    logic  byte_hs, coef_hs, clr;
    coef_t c_out, neg;
    logic [IDXW-1:0] c_idx;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        idx_d   = idx_q;
        in_rdy  = 1'b0;
        c_vld   = 1'b0;
        c_last  = 1'b0;
        c_out   = '0;
        c_idx   = '0;
        dn      = 1'b0;
        clr     = 1'b0;
        byte_hs = 1'b0;
        coef_hs = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    cnt_d   = '0;
                    rx_d    = '0;
                    idx_d   = '0;
                    clr     = 1'b1;
                end
            end
            S_RUN: begin
                in_rdy  = (cnt_q < CNTW'(LOGQ)) && (rx_q < RXW'(NBYTES));
                c_vld   = (cnt_q >= CNTW'(LOGQ));
                c_out   = acc_q[LOGQ-1:0];
                c_idx   = idx_q;
                byte_hs = in_rdy && bus.in_valid;
                coef_hs = c_vld && bus.coef_ready;
                if (byte_hs) begin
                    acc_d = acc_q | (ACCW'(bus.in_byte) << cnt_q);
                    cnt_d = cnt_q + CNTW'(8);
                    rx_d  = rx_q + RXW'(1);
                end
                if (coef_hs) begin
                    acc_d = acc_q >> LOGQ;
                    cnt_d = cnt_q - CNTW'(LOGQ);
                    idx_d = idx_q + IDXW'(1);
                    if (idx_q == IDXW'(N - 2)) begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                c_vld  = 1'b1;
                c_last = 1'b1;
                c_out  = neg;
                c_idx  = IDXW'(N - 1);
                if (bus.coef_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                dn      = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            rx_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            idx_q   <= idx_d;
        end
    end

    rq0_last_coef u_last (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .add_i  (coef_hs),
        .coef_i (c_out),
        .neg_o  (neg)
    );

    assign bus.in_ready   = in_rdy;
    assign bus.coef_valid = c_vld;
    assign bus.coef       = c_out;
    assign bus.coef_idx   = c_idx;
    assign bus.coef_last  = c_last;
    assign bus.done       = dn;

`ifdef UNPACK_PAD_CHECK_EN
    // acc[16:13] are the pad bits left once coefficient N-2 shifts out
    logic pad_q;
    logic pad_set;

    assign pad_set = coef_hs && (idx_q == IDXW'(N - 2))
                     && (acc_q[LOGQ+3:LOGQ] != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_q <= 1'b0;
        end else if (clr) begin
            pad_q <= 1'b0;
        end else if (pad_set) begin
            pad_q <= 1'b1;
        end
    end

    assign bus.pad_err = pad_q;
`else
    assign bus.pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_unpack_rq0_stream.sv
// Scoreboard bench for unpack_rq0_stream: bit-level reference unpack,
// random valid/ready gaps, mid-frame start pulses and mid-frame reset.
module tb_unpack_rq0_stream;
    import ntru_pkg::*;

    typedef struct {
        int idx;
        int coef;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unpack_rq0_stream_if bus();

    unpack_rq0_stream dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0] fb [NBYTES];
    exp_t sb [$];
    bit   exp_pad;
    int   done_cnt = 0;
    bit   first_pending = 0;
    int   first_cyc = 0;

    bit          p_stall = 0;
    logic [12:0] p_coef;
    logic [9:0]  p_idx;
    logic        p_last;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: read coefficient i straight from stream bits 13i..13i+12
    function automatic void build_exp();
        int s;
        int v;
        int pos;
        int padbits;
        s = 0;
        sb.delete();
        for (int i = 0; i < N - 1; i++) begin
            v = 0;
            for (int b = 0; b < LOGQ; b++) begin
                pos = LOGQ * i + b;
                if (fb[pos / 8][pos % 8]) v = v | (1 << b);
            end
            sb.push_back('{i, v, 1'b0});
            s = (s + v) % Q;
        end
        sb.push_back('{N - 1, (Q - s) % Q, 1'b1});
        padbits = 0;
        for (int p = (N - 1) * LOGQ; p < NBYTES * 8; p++) begin
            if (fb[p / 8][p % 8]) padbits++;
        end
`ifdef UNPACK_PAD_CHECK_EN
        exp_pad = (padbits != 0);
`else
        exp_pad = 1'b0;
`endif
    endfunction

    // Monitor: pops the scoreboard on every coefficient handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            p_stall = 0;
        end else begin
            if (first_pending && bus.coef_valid) begin
                first_cyc = cyc;
                first_pending = 0;
            end
            if (p_stall) begin
                chk("hold", int'({bus.coef_valid, bus.coef_last, bus.coef_idx, bus.coef}),
                    int'({1'b1, p_last, p_idx, p_coef}));
            end
            if (bus.coef_valid && bus.coef_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_coef: idx %0d with empty scoreboard", bus.coef_idx);
                end else begin
                    e = sb.pop_front();
                    chk("coef_idx", int'(bus.coef_idx), e.idx);
                    chk("coef", int'(bus.coef), e.coef);
                    chk("coef_last", int'(bus.coef_last), int'(e.last));
                    if (e.last) chk("pad_err", int'(bus.pad_err), int'(exp_pad));
                end
            end
            p_stall = bus.coef_valid && !bus.coef_ready;
            p_coef  = bus.coef;
            p_idx   = bus.coef_idx;
            p_last  = bus.coef_last;
            if (bus.done) begin
                done_cnt++;
                chk("done_after_last", sb.size(), 0);
            end
        end
    end

    task automatic drive(input int in_gap, input int rdy_gap, input bit mid_start, input int ptr);
        bus.in_valid   = ($urandom_range(99) >= in_gap);
        bus.in_byte    = (ptr < NBYTES) ? fb[ptr] : 8'h00;
        bus.coef_ready = ($urandom_range(99) >= rdy_gap);
        bus.start      = mid_start && ($urandom_range(39) == 0);
    endtask

    task automatic run_frame(input int in_gap, input int rdy_gap, input bit mid_start,
                             input int abort_at, input bit chk_lat);
        int ptr;
        int ncoef;
        int s_cyc;
        int budget;
        int d0;
        bit tb_hs;
        bit tc_hs;
        bit sawd;
        ptr = 0;
        ncoef = 0;
        budget = 0;
        d0 = done_cnt;
        build_exp();
        @(posedge clk); #1;
        bus.start = 1'b1;
        s_cyc = cyc;
        first_pending = 1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drive(in_gap, rdy_gap, 1'b0, ptr);
        while (1) begin
            @(negedge clk);
            tb_hs = bus.in_valid && bus.in_ready;
            tc_hs = bus.coef_valid && bus.coef_ready;
            sawd  = bus.done;
            @(posedge clk); #1;
            if (tb_hs) ptr++;
            if (tc_hs) ncoef++;
            if (sawd) break;
            if (abort_at > 0 && ncoef == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("reset_outputs", int'({bus.in_ready, bus.coef_valid, bus.coef_last,
                                           bus.done, bus.pad_err, bus.coef_idx, bus.coef}), 0);
                sb.delete();
                bus.in_valid = 1'b0;
                bus.coef_ready = 1'b0;
                bus.start = 1'b0;
                @(posedge clk);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            budget++;
            if (budget > 20000) begin
                total++;
                bad++;
                $display("FAIL timeout: %0d coefs, %0d bytes taken, no done", ncoef, ptr);
                sb.delete();
                bus.start = 1'b0;
                bus.in_valid = 1'b0;
                return;
            end
            drive(in_gap, rdy_gap, mid_start, ptr);
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("sb_empty", sb.size(), 0);
        chk("bytes_taken", ptr, NBYTES);
        chk("coefs_taken", ncoef, N);
        if (chk_lat) chk("first_latency", first_cyc - s_cyc, 3);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.in_byte = 8'h00;
        bus.in_valid = 1'b0;
        bus.coef_ready = 1'b0;
        #1;
        chk("reset_state", int'({bus.in_ready, bus.coef_valid, bus.coef_last,
                                 bus.done, bus.pad_err, bus.coef_idx, bus.coef}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NBYTES; i++) fb[i] = 8'h00;
        run_frame(0, 0, 1'b0, 0, 1'b1);

        fb[0] = 8'h01;
        run_frame(20, 20, 1'b0, 0, 1'b0);

        for (int i = 0; i < NBYTES; i++) fb[i] = 8'hFF;
        fb[NBYTES-1] = 8'h0F;
        run_frame(0, 0, 1'b0, 0, 1'b1);

        fb[NBYTES-1] = 8'hFF;
        run_frame(10, 30, 1'b0, 0, 1'b0);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NBYTES; i++) fb[i] = 8'($urandom);
            run_frame(35, 40, 1'b1, 0, 1'b0);
        end

        for (int i = 0; i < NBYTES; i++) fb[i] = 8'h00;
        run_frame(15, 15, 1'b0, 301, 1'b0);
        run_frame(0, 0, 1'b0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
